wb_arbiter: RTL
===============

# wb_arbiter

Write-back arbiter and register scoreboard for the integer pipeline. Shares the single register-file write port among NUM_REQ write-back sources (ALU, load unit, CSR/misc) with a valid/ready handshake. Drives the write port from registered outputs, at most one write per cycle. Keeps a 32-bit busy scoreboard of destination registers with writes in flight, which decode uses for hazard stalls.

## Interface
- NUM_REQ, 3, number of write-back requesters (2..4); index 0 is highest priority when the round-robin pointer is 0
- DATA_W, 32, write data width
- ADDR_W, 5, register address width (32 registers)

- clk_in  input  1  clock, all state on rising edge
- rst_n_in  input  1  asynchronous, active-low reset
- rdy_in  input  1  global enable; low freezes all state
- req_valid  input  NUM_REQ  requester i has a write pending
- req_rd  input  NUM_REQ*ADDR_W  destination register of requester i, slice [i*ADDR_W +: ADDR_W]
- req_data  input  NUM_REQ*DATA_W  write data of requester i, slice [i*DATA_W +: DATA_W]
- req_ready  output  NUM_REQ  one-hot grant; combinational
- rsv_valid  input  1  decode reserves a destination register
- rsv_rd  input  ADDR_W  register being reserved
- busy_vec  output  32  bit r set means register r has a write in flight; registered
- write_flag  output  1  register-file write enable; registered
- reg_write  output  ADDR_W  register-file write address; registered
- write_data  output  DATA_W  register-file write data; registered

## Operation
- Transfer on requester i: req_valid[i] && req_ready[i] at a rising edge.
- req_ready is all-zero when rdy_in=0 or no req_valid bit is set. Otherwise exactly one bit is set: the first valid requester scanning upward (with wrap) from rr_ptr.
- req_ready[i] must not depend on req_data or req_rd.
- Requesters hold valid, rd and data stable until a transfer.
- On a transfer from requester g:
  - reg_write <= req_rd[g]
  - write_data <= req_data[g]
  - write_flag <= (req_rd[g] != 0)
  - rr_ptr <= (g+1) mod NUM_REQ
- A write to x0 is consumed: ready is given and the pointer advances, but write_flag stays 0.
- Cycle with rdy_in=1 and no transfer: write_flag <= 0. reg_write and write_data hold.
- Scoreboard, with rdy_in=1 at each edge:
  - Clear: if a transfer with rd != 0 occurs, clear busy[rd].
  - Set: if rsv_valid && rsv_rd != 0, set busy[rsv_rd].
  - Set and clear of the same register in one cycle: set wins, because a new producer is now in flight.
  - busy[0] is constantly 0.
  - Reserving an already-busy register leaves it busy. There is no counting; decode must not issue a second producer to a busy register.
- rdy_in=0: no grants; every register (outputs, rr_ptr, busy_vec) holds its value; rsv_valid is ignored.

## Timing
- Reset (rst_n_in low, asynchronous): write_flag=0, reg_write=0, write_data=0, busy_vec=0, rr_ptr=0. Since req_ready is combinational, it still reflects the inputs under the reset pointer.
- Reset mid-operation: in-flight grants are lost and the scoreboard is cleared. Upstream is reset by the same signal.
- Latency: a transfer at edge N gives write_flag=1 for cycle N..N+1, and the register file commits at edge N+1. Back-to-back transfers give write_flag high on consecutive cycles.
- busy_vec clear becomes visible in the same cycle that write_flag presents the data. Decode combines this with the register file's write-through to read the value without a bubble.
- Throughput: one transfer per cycle. With NUM_REQ requesters continuously valid, each waits at most NUM_REQ-1 cycles.

## Configuration
- WB_ARB_RR_EN defined: round-robin as described; rr_ptr advances after every transfer.
- WB_ARB_RR_EN undefined: fixed priority. rr_ptr is held at 0 and not synthesised, and the lowest-index valid requester always wins. Starvation of higher indices is permitted.

## Test plan
- Reset then idle: busy_vec=0, write_flag=0, req_ready=0 -> all remain 0 for 10 cycles.
- Single requester: req_valid=001, rd=5, data=0xDEADBEEF -> req_ready=001 the same cycle; next cycle write_flag=1, reg_write=5, write_data=0xDEADBEEF; following cycle write_flag=0.
- Round-robin (WB_ARB_RR_EN defined), all three valid continuously with rd 1/2/3 -> grants 0,1,2,0,1,2 on consecutive cycles; reg_write sequence 1,2,3,1,2,3. Without the macro -> grant 0 every cycle.
- Scoreboard:
  - Reserve rd=7 -> busy_vec[7]=1 next cycle.
  - Transfer rd=7 -> busy_vec[7]=0 next cycle.
  - Reserve and transfer rd=7 in the same cycle -> busy_vec[7] stays 1.
  - Reserve rd=0 -> busy_vec unchanged.
- x0 write: transfer rd=0, data=0x1234 -> req_ready asserted, write_flag stays 0, rr_ptr advances.
- Stall and reset: rdy_in=0 with requests pending -> req_ready=0 and outputs frozen; reassert -> resumes at the same pointer. Pull rst_n_in low mid-burst -> outputs and busy_vec go 0 without waiting for a clock edge.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: write-back arbiter for the single register-file write port,
// plus the 32-entry busy scoreboard used by decode for hazard stalls.
// Build option: define WB_ARB_RR_EN for round-robin arbitration; without it
// the arbiter is fixed priority (lowest index wins) and no pointer is kept.
module wb_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic                        rdy_in,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_rd,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        rsv_valid,
    input  logic [ADDR_W-1:0]           rsv_rd,
    output logic [31:0]                 busy_vec,
    output logic                        write_flag,
    output logic [ADDR_W-1:0]           reg_write,
    output logic [DATA_W-1:0]           write_data
);

    localparam int unsigned PTR_W    = (NUM_REQ > 2) ? 2 : 1;
    localparam int unsigned NUM_REGS = 32;

    logic [PTR_W-1:0]    w_rr_ptr;
    logic [PTR_W-1:0]    w_gnt_idx;
    logic                w_xfer;
    logic [ADDR_W-1:0]   w_sel_rd;
    logic [DATA_W-1:0]   w_sel_data;
    logic [NUM_REGS-1:0] w_busy_nxt;

    // (base + off) mod NUM_REQ, used for the scan order and pointer advance
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input int unsigned      off);
        int unsigned sum;
        sum = 32'(base) + off;
        return PTR_W'(sum % NUM_REQ);
    endfunction

`ifdef WB_ARB_RR_EN
    logic [PTR_W-1:0] r_rr_ptr;

    // Round-robin pointer: moves just past the requester that was served
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_rr_ptr <= '0;
        end else if (rdy_in && w_xfer) begin
            r_rr_ptr <= wrap_add(w_gnt_idx, 1);
        end
    end

    assign w_rr_ptr = r_rr_ptr;
`else
    assign w_rr_ptr = '0;
`endif

    // Grant: first valid requester scanning upward from the pointer; only
    // valid bits and the pointer feed this path, never rd or data
    always_comb begin
        w_xfer    = 1'b0;
        w_gnt_idx = '0;
        req_ready = '0;
        if (rdy_in) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (!w_xfer && req_valid[wrap_add(w_rr_ptr, k)]) begin
                    w_xfer    = 1'b1;
                    w_gnt_idx = wrap_add(w_rr_ptr, k);
                end
            end
        end
        if (w_xfer) begin
            req_ready[w_gnt_idx] = 1'b1;
        end
    end

    // Payload of the granted requester
    assign w_sel_rd   = req_rd[w_gnt_idx*ADDR_W +: ADDR_W];
    assign w_sel_data = req_data[w_gnt_idx*DATA_W +: DATA_W];

    // Scoreboard next state: clear on write-back, then set on reserve so a
    // new producer for the same register keeps it busy; x0 never busy
    always_comb begin
        w_busy_nxt = busy_vec;
        if (w_xfer && (w_sel_rd != '0)) begin
            w_busy_nxt[w_sel_rd] = 1'b0;
        end
        if (rsv_valid && (rsv_rd != '0)) begin
            w_busy_nxt[rsv_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Register-file write port and scoreboard; rdy_in low freezes everything
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            write_flag <= 1'b0;
            reg_write  <= '0;
            write_data <= '0;
            busy_vec   <= '0;
        end else if (rdy_in) begin
            busy_vec <= w_busy_nxt;
            if (w_xfer) begin
                reg_write  <= w_sel_rd;
                write_data <= w_sel_data;
                write_flag <= (w_sel_rd != '0);
            end else begin
                write_flag <= 1'b0;
            end
        end
    end

endmodule
